// File: rtl/hba_arbiter_if.sv
// HBA arbitration bundle: request/ack inputs and registered grant/watchdog outputs.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface hba_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int OWNER_WIDTH = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0] hba_mrequest;
    logic                   hba_xferack;
    logic [NUM_MASTERS-1:0] hba_mgrant;
    logic                   hba_xferack_arb;
    logic [OWNER_WIDTH-1:0] arb_owner;
    logic                   arb_busy;
    logic                   arb_timeout;

    modport master (
        output hba_mrequest, hba_xferack,
        input  hba_mgrant, hba_xferack_arb, arb_owner, arb_busy, arb_timeout
    );

    modport slave (
        input  hba_mrequest, hba_xferack,
        output hba_mgrant, hba_xferack_arb, arb_owner, arb_busy, arb_timeout
    );
endinterface

// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter: one grant at a time, held until the owner drops its
// request, with a watchdog that forces an ack when no slave answers.
module hba_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int OWNER_WIDTH    = $clog2(NUM_MASTERS)
) (
    input  logic          hba_clk,
    input  logic          hba_reset,
    hba_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [OWNER_WIDTH-1:0] ptr_q, ptr_d;
    logic [OWNER_WIDTH-1:0] owner_q, owner_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   tmo_q, tmo_d;
    logic [OWNER_WIDTH-1:0] pick;

    // First requester at or after ptr, wrapping modulo NUM_MASTERS.
    function automatic logic [OWNER_WIDTH-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [OWNER_WIDTH-1:0] start
    );
        logic [OWNER_WIDTH-1:0] sel;
        logic [OWNER_WIDTH-1:0] cand;
        logic                   hit;
        int                     idx;
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            cand = OWNER_WIDTH'(idx);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        return sel;
    endfunction

    assign pick = rr_pick(bus.hba_mrequest, ptr_q);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|bus.hba_mrequest) begin
                    grant_d = NUM_MASTERS'(1) << pick;
                    owner_d = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!bus.hba_mrequest[owner_q]) begin
                    grant_d = '0;
                    ptr_d   = (owner_q == OWNER_WIDTH'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (WD_EN) begin
                    // A real slave ack wins over an expiry on the same cycle.
                    if (bus.hba_xferack) begin
                        cnt_d = '0;
                    end else if (cnt_q == WD_LAST) begin
                        cnt_d = '0;
                        tmo_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = |grant_d;
    end

    always_ff @(posedge hba_clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
        if (hba_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.hba_mgrant      = grant_q;
    assign bus.arb_owner       = owner_q;
    assign bus.arb_busy        = busy_q;
    assign bus.hba_xferack_arb = tmo_q;
    assign bus.arb_timeout     = tmo_q;
endmodule

// File: tb/tb_hba_arbiter.sv
// Bench for hba_arbiter: directed scenarios with literal expectations plus a long random
// run against a behavioural model; a second instance has the watchdog disabled.
module tb_hba_arbiter;
    localparam int N = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    int total = 0;
    int bad   = 0;

    hba_arbiter_if #(.NUM_MASTERS(N), .OWNER_WIDTH(2)) bus0 ();
    hba_arbiter_if #(.NUM_MASTERS(N), .OWNER_WIDTH(2)) bus1 ();

    hba_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(T), .OWNER_WIDTH(2)) dut (
        .hba_clk(clk), .hba_reset(rst0), .bus(bus0)
    );
    hba_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(0), .OWNER_WIDTH(2)) dut_nowd (
        .hba_clk(clk), .hba_reset(rst1), .bus(bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, where the next search starts, and how many
    // consecutive unanswered grant cycles have gone by in the current watchdog window.
    int         m_cur = -1;
    int         m_ptr = 0;
    int         m_owner = 0;
    int         m_quiet = 0;
    bit         m_pulse = 1'b0;
    logic [3:0] m_grant = 4'b0;
    bit         model_live = 1'b0;
    bit         nw_on = 1'b0;

    always @(posedge clk) begin
        if (rst0) begin
            m_cur = -1; m_ptr = 0; m_owner = 0; m_quiet = 0; m_pulse = 1'b0;
        end else if (m_cur < 0) begin
            m_pulse = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_cur < 0 && bus0.hba_mrequest[(m_ptr + k) % N]) begin
                    m_cur   = (m_ptr + k) % N;
                    m_owner = m_cur;
                    m_quiet = 0;
                end
            end
        end else if (!bus0.hba_mrequest[m_cur]) begin
            m_ptr   = (m_cur + 1) % N;
            m_cur   = -1;
            m_pulse = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (bus0.hba_xferack) begin
                m_quiet = 0;
            end else if (m_quiet == T - 1) begin
                m_pulse = 1'b1;
                m_quiet = 0;
            end else begin
                m_quiet = m_quiet + 1;
            end
        end
        m_grant    = (m_cur < 0) ? 4'b0 : (4'b1 << m_cur);
        nw_on      = !rst1;
        model_live = 1'b1;
    end

    int nw_grant_cycles = 0;
    int nw_pulses = 0;

    always @(negedge clk) begin
        if (model_live) begin
            check("grant", bus0.hba_mgrant, m_grant);
            check("owner", bus0.arb_owner, m_owner);
            check("busy", bus0.arb_busy, (m_cur >= 0));
            check("xferack_arb", bus0.hba_xferack_arb, m_pulse);
            check("timeout", bus0.arb_timeout, m_pulse);
            check("nowd_grant", bus1.hba_mgrant, nw_on ? 4'b0010 : 4'b0000);
            check("nowd_ack", bus1.hba_xferack_arb, 1'b0);
            if (bus1.hba_mgrant == 4'b0010) nw_grant_cycles++;
            if (bus1.hba_xferack_arb || bus1.arb_timeout) nw_pulses++;
        end
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        bus0.hba_mrequest = '0;
        bus0.hba_xferack  = 1'b0;
        bus1.hba_mrequest = 4'b0010;
        bus1.hba_xferack  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", bus0.hba_mgrant, 4'b0000);
        check("rst_owner", bus0.arb_owner, 2'd0);
        check("rst_busy", bus0.arb_busy, 1'b0);
        check("rst_ack", bus0.hba_xferack_arb, 1'b0);
        check("rst_tmo", bus0.arb_timeout, 1'b0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Single request: grant next cycle, release the cycle after the drop.
        bus0.hba_mrequest = 4'b0100;
        @(negedge clk);
        check("t1_grant", bus0.hba_mgrant, 4'b0100);
        check("t1_owner", bus0.arb_owner, 2'd2);
        check("t1_busy", bus0.arb_busy, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_hold", bus0.hba_mgrant, 4'b0100);
        bus0.hba_mrequest = 4'b0000;
        @(negedge clk);
        check("t1_release", bus0.hba_mgrant, 4'b0000);
        check("t1_owner_kept", bus0.arb_owner, 2'd2);

        // Everyone requesting: strict rotation with a dead cycle between owners.
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        bus0.hba_mrequest = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int waited;
            waited = 0;
            @(negedge clk);
            while (bus0.hba_mgrant == 4'b0 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            check("rot_order", bus0.hba_mgrant, 4'b0001 << (k % 4));
            repeat (2) @(negedge clk);
            check("rot_hold", bus0.hba_mgrant, 4'b0001 << (k % 4));
            bus0.hba_mrequest[k % 4] = 1'b0;
            @(negedge clk);
            check("rot_gap", bus0.hba_mgrant, 4'b0000);
            bus0.hba_mrequest = 4'b1111;
        end
        @(negedge clk);
        bus0.hba_mrequest = 4'b0000;
        @(negedge clk);

        // Fairness: master 3 pending while master 0 re-requests with ptr at 1.
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        bus0.hba_mrequest = 4'b0001;
        @(negedge clk);
        check("fair_g0", bus0.hba_mgrant, 4'b0001);
        bus0.hba_mrequest = 4'b1000;
        @(negedge clk);
        check("fair_gap", bus0.hba_mgrant, 4'b0000);
        bus0.hba_mrequest = 4'b1001;
        @(negedge clk);
        check("fair_g3", bus0.hba_mgrant, 4'b1000);
        bus0.hba_mrequest = 4'b0001;
        @(negedge clk);
        check("fair_gap2", bus0.hba_mgrant, 4'b0000);
        @(negedge clk);
        check("fair_g0_again", bus0.hba_mgrant, 4'b0001);
        bus0.hba_mrequest = 4'b0000;
        @(negedge clk);

        // Watchdog: pulses at +8 and +16, ack at +23 defers to +32, drop on the +40 pulse.
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        bus0.hba_mrequest = 4'b0010;
        @(negedge clk);
        check("wd_grant", bus0.hba_mgrant, 4'b0010);
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            check("wd_pulse", bus0.hba_xferack_arb, (i == 8 || i == 16 || i == 32 || i == 40));
            check("wd_tmo", bus0.arb_timeout, (i == 8 || i == 16 || i == 32 || i == 40));
            check("wd_grant_held", bus0.hba_mgrant, (i <= 40) ? 4'b0010 : 4'b0000);
            if (i == 23) bus0.hba_xferack = 1'b1;
            if (i == 24) bus0.hba_xferack = 1'b0;
            if (i == 40) bus0.hba_mrequest = 4'b0000;
        end

        // Reset mid-grant with requests still high; search restarts at master 0.
        bus0.hba_mrequest = 4'b0100;
        @(negedge clk);
        check("mid_grant", bus0.hba_mgrant, 4'b0100);
        bus0.hba_mrequest = 4'b1111;
        repeat (2) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check("mid_rst_grant", bus0.hba_mgrant, 4'b0000);
        check("mid_rst_busy", bus0.arb_busy, 1'b0);
        check("mid_rst_owner", bus0.arb_owner, 2'd0);
        rst0 = 1'b0;
        @(negedge clk);
        check("post_rst_grant", bus0.hba_mgrant, 4'b0001);
        bus0.hba_mrequest = 4'b0000;

        // Long random run; also keeps the no-watchdog instance granted past 65536 cycles.
        for (int c = 0; c < 66000; c++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++)
                if ($urandom_range(15) == 0) bus0.hba_mrequest[b] = ~bus0.hba_mrequest[b];
            bus0.hba_xferack = ($urandom_range(9) == 0);
            rst0 = ($urandom_range(2999) == 0);
        end
        rst0 = 1'b0;
        @(negedge clk);

        check("nowd_pulses", nw_pulses, 0);
        check("nowd_long_hold", (nw_grant_cycles > 65535), 1'b1);
        check("nowd_final_grant", bus1.hba_mgrant, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hba_arbiter.md
# hba_arbiter

Round-robin bus arbiter for the HomeBrew Automation (HBA) bus. It shares the single HBA master port between up to NUM_MASTERS requesters, such as the serial bridge and future DMA or sequencer masters. It grants exactly one master at a time and holds the grant until that master drops its request. A watchdog terminates transfers that no slave acknowledges, so a missing peripheral cannot hang the bus.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesters, 2..16.
- TIMEOUT_CYCLES, 255: cycles without hba_xferack before a forced ack; 0 disables the watchdog; maximum 65535.
- OWNER_WIDTH, $clog2(NUM_MASTERS): width of arb_owner.

Ports (name, direction, width, meaning):
- hba_clk  in  1  sole clock; all logic on posedge.
- hba_reset  in  1  synchronous, active-high reset.
- hba_mrequest  in  NUM_MASTERS  per-master request; bit i belongs to master i.
- hba_xferack  in  1  OR of all slave xferacks; excludes hba_xferack_arb.
- hba_mgrant  out  NUM_MASTERS  one-hot-or-zero grant, registered.
- hba_xferack_arb  out  1  watchdog ack pulse; the top level ORs it into the bus xferack seen by masters.
- arb_owner  out  OWNER_WIDTH  index of the current grantee; holds the last value when idle.
- arb_busy  out  1  high while any grant is asserted.
- arb_timeout  out  1  one-cycle pulse coincident with hba_xferack_arb.

Masters drive their abus, dbus, rnw and select to zero when not granted. The bus data path is a plain OR of master outputs, outside this block.

## Operation
- State machine has two states: IDLE and GRANT.
- In IDLE, hba_mgrant = 0.
  - If any request bit is set, select the first set bit searching ptr, ptr+1, … wrapping modulo NUM_MASTERS.
  - Register hba_mgrant = 1<<sel and arb_owner = sel, then go to GRANT.
- In GRANT, the grant is held while hba_mrequest[arb_owner] = 1. Other requests are ignored and no preemption occurs.
- When hba_mrequest[arb_owner] = 0:
  - clear hba_mgrant;
  - set ptr = (arb_owner+1) mod NUM_MASTERS (wrap from NUM_MASTERS-1 to 0);
  - go to IDLE.
- Watchdog, active only when TIMEOUT_CYCLES != 0:
  - A 16-bit counter clears on entry to GRANT and on every cycle where hba_xferack = 1.
  - Otherwise it increments each GRANT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with no hba_xferack that cycle, the next cycle pulses hba_xferack_arb and arb_timeout for exactly one cycle, and the counter clears.
  - The grant is not revoked; the master sees a completed transfer and drops its request normally.
  - hba_xferack_arb never asserts in IDLE.
- Simultaneous events:
  - A slave ack on the same cycle the counter would expire takes priority: no timeout pulse.
  - A request drop on the same cycle as a timeout pulse still releases the grant the following cycle.
- Reset values:
  - hba_mgrant = 0, arb_owner = 0, arb_busy = 0, hba_xferack_arb = 0, arb_timeout = 0.
  - ptr = 0, counter = 0, state = IDLE.
- Reset mid-grant drops hba_mgrant on the cycle after reset is sampled. The counter is discarded.
- Request bits at index ≥ NUM_MASTERS do not exist.

## Timing
- Grant latency: a request sampled in IDLE at cycle n gives hba_mgrant high at n+1.
- Release: a request drop sampled at cycle n gives hba_mgrant low at n+1, with state IDLE at n+1.
- Dead cycle: the next grant is visible no earlier than n+2. This guarantees one bus-idle cycle with no grant between owners.
- Timeout latency: the forced ack appears TIMEOUT_CYCLES cycles after grant or after the last slave ack.
- All outputs are registered; there is no combinational path from inputs to outputs.
- arb_busy equals |hba_mgrant.

## Test plan
- Reset, then hba_mrequest = 4'b0100 at cycle 0 → hba_mgrant = 4'b0100 and arb_owner = 2 at cycle 1. Drop the request at cycle 5 → hba_mgrant = 0 at cycle 6.
- hba_mrequest = 4'b1111 held constantly, each owner dropping its request for one cycle after 3 cycles of grant → grant order 0, 1, 2, 3, 0, with at least one zero-grant cycle between each grant.
- Fairness: master 0 re-requests immediately while master 3 is pending and ptr = 1 → master 3 is granted before master 0.
- Watchdog with TIMEOUT_CYCLES = 8: grant master 1, never ack → hba_xferack_arb and arb_timeout pulse exactly 8 cycles after the grant, again 8 cycles later, and grant stays 4'b0010 until the request drops. Slave ack at cycle 7 → no pulse, and the counter restarts.
- TIMEOUT_CYCLES = 0: hold grant with no ack for 70000 cycles → no hba_xferack_arb ever.
- Assert hba_reset mid-grant with requests still high → hba_mgrant = 0 at the next cycle. After reset releases, master 0 is granted first (ptr = 0).
